irq_controller: RTL and testbench
=================================

# irq_controller

Memory-mapped interrupt aggregator for the m6502 SoC that sits directly downstream of the peripherals, timer included. It collects up to eight active-high peripheral IRQ lines, latches or passes them per source (edge/level), masks them, prioritises them, and drives a single IRQ request toward the CPU. The top level inverts `o_irq` onto the CPU's active-low IRQ pin.

## Interface
Parameters:
- `NUM_SRC`, default 8: number of interrupt sources, legal range 1..8. Source 0 has the highest priority.

Ports:
- `i_clk` in 1: system clock. The only clock; all state is on the rising edge.
- `i_reset_n` in 1: reset, synchronous and active-low.
- `i_src` in NUM_SRC: peripheral IRQ lines, active-high, synchronous to `i_clk`.
- `i_addr` in 3: register select.
- `i_data` in 8: write data.
- `i_rw` in 1: 1 = read, 0 = write.
- `i_en` in 1: bus access strobe. Each high cycle is one access.
- `o_data` out 8: registered read data.
- `o_irq` out 1: registered, active-high CPU interrupt request.

## Operation
Register map. Bits at or above NUM_SRC read 0 and ignore writes.
- 0 RAW (RO): current `i_src` levels.
- 1 ENABLE (RW): per-source mask, 1 = enabled.
- 2 MODE (RW): 1 = edge mode, 0 = level mode.
- 3 PENDING (R, W1C):
  - Reads `pending = (latch & MODE) | (i_src & ~MODE)`.
  - Writing 1 clears the corresponding edge latch. Has no effect on level-mode bits.
- 4 ACTIVE (RO):
  - bit7 = valid, which is `|(pending & ENABLE)`.
  - bits[2:0] = index of the lowest-numbered pending and enabled source.
  - Reads 0x00 when nothing is active.
- 5 SWSET (WO): writing 1 sets the edge latch of edge-mode sources (software trigger). Reads 0.
- 6, 7: reserved. Reads return 0; writes are ignored.

Edge latch rules:
- Register `src_q` holds the previous `i_src` sample.
- A rising edge is `i_src & ~src_q`. It sets the latch only when MODE = 1.
- The latch captures edges regardless of ENABLE.
- The latch is forced to 0 in every cycle its MODE bit is 0. Switching a source to edge mode therefore starts it clean.
- Precedence per bit, in one cycle: hardware edge or SWSET set > W1C clear. Set wins.

Output and read path:
- `o_irq` is the registered value of `|(pending & ENABLE)`.
- `o_data` updates only on a cycle with `i_en && i_rw`, and holds otherwise. It captures the register values that are current before that edge's updates.
- Reads have no side effects.

## Timing
- Reset (while `i_reset_n` = 0 at a rising edge) clears all of: ENABLE, MODE, latch, `src_q`, `o_data`, `o_irq`. Reset has priority over any simultaneous access.
- Latency of an edge-mode source, when `i_src` is first sampled high at edge k:
  - the latch is 1 after edge k;
  - PENDING and ACTIVE reflect it for a read strobed at edge k+1;
  - `o_irq` is 1 after edge k+1.
- Level-mode source: `o_irq` follows `i_src & ENABLE` with one cycle of latency.
- Masking: a write to ENABLE at edge k takes effect in the `o_irq` value after edge k+1.
- W1C at edge k:
  - the latch is 0 after edge k;
  - `o_irq` drops after edge k+1 if nothing else is active;
  - an edge arriving at the same edge k keeps the latch at 1.
- A source held high in edge mode produces only one latch set. A new set needs a low sample, then a high sample.
- Reset mid-operation: the first cycle after release sees `src_q` = 0 but MODE = 0, so no latch is set.

## Structure
- Package `irq_ctrl_pkg` holds:
  - register address localparams IRQ_RAW … IRQ_SWSET;
  - ACTIVE_VALID_BIT = 7;
  - MAX_SRC = 8.
- Sub-module `irq_prio_enc` is purely combinational. Input: `pending & ENABLE`. Outputs: valid and the 3-bit index. Lowest index wins.
- The top module holds the registers, edge detection, the bus read/write logic, and the `o_irq` flop.

## Test plan
- Reset, then read every address: all read 0x00 and `o_irq` = 0. Write 0xFF to address 6, then read it: reads 0x00.
- Edge path:
  - Setup: MODE = 0x01, ENABLE = 0x01.
  - Pulse `i_src[0]` for 1 cycle at edge k: `o_irq` = 1 after edge k+1, PENDING reads 0x01, ACTIVE reads 0x80.
  - Write 0x01 to PENDING: `o_irq` = 0 two cycles later and stays 0 while `i_src[0]` stays high.
- Level path:
  - Setup: MODE = 0x00, ENABLE = 0x04.
  - Hold `i_src[2]` high: `o_irq` = 1 and ACTIVE = 0x82.
  - W1C 0x04 leaves PENDING = 0x04. Drop `i_src[2]`: `o_irq` = 0 one cycle later.
- Priority and mask:
  - Setup: sources 3 and 5 pending, ENABLE = 0x28. ACTIVE = 0x83.
  - Set ENABLE = 0x20: ACTIVE = 0x85.
  - Set ENABLE = 0x00: ACTIVE = 0x00 and `o_irq` = 0, while PENDING still reads 0x28.
- Collision and SWSET:
  - Setup: MODE = 0x02. A W1C of 0x02 lands in the same cycle as a rising edge on `i_src[1]`. Required: the latch stays 1.
  - SWSET 0x02 with MODE bit 1 = 0: no effect.
  - Assert `i_reset_n` = 0 while `o_irq` = 1: `o_irq` = 0 after that edge.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the m6502 interrupt aggregator: register map and field positions.
package irq_ctrl_pkg;
  localparam int MAX_SRC          = 8;
  localparam int ACTIVE_VALID_BIT = 7;

  localparam logic [2:0] IRQ_RAW     = 3'd0;
  localparam logic [2:0] IRQ_ENABLE  = 3'd1;
  localparam logic [2:0] IRQ_MODE    = 3'd2;
  localparam logic [2:0] IRQ_PENDING = 3'd3;
  localparam logic [2:0] IRQ_ACTIVE  = 3'd4;
  localparam logic [2:0] IRQ_SWSET   = 3'd5;
endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: lowest-numbered asserted request wins.
module irq_prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [2:0]         idx
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    valid = |req;
    idx   = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt aggregator: per-source edge/level capture, mask, priority, CPU request.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NUM_SRC-1:0] i_src,
  input  logic [2:0]         i_addr,
  input  logic [7:0]         i_data,
  input  logic               i_rw,
  input  logic               i_en,
  output logic [7:0]         o_data,
  output logic               o_irq
);

  logic [NUM_SRC-1:0] enable_r, mode_r, latch_r, src_q_r;
  logic [NUM_SRC-1:0] wdata_s, pending_s, rise_s, set_s, clr_s, latch_nxt_s, req_s;
  logic               wr_s, rd_s, act_valid_s;
  logic [2:0]         act_idx_s;
  logic [7:0]         active_s, rdata_s;

  assign wr_s      = i_en & ~i_rw;
  assign rd_s      = i_en & i_rw;
  assign wdata_s   = i_data[NUM_SRC-1:0];
  assign pending_s = (latch_r & mode_r) | (i_src & ~mode_r);
  assign rise_s    = i_src & ~src_q_r;
  assign req_s     = pending_s & enable_r;

  irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .req   (req_s),
    .valid (act_valid_s),
    .idx   (act_idx_s)
  );

  // Next edge-latch value: sets beat W1C clears, and level-mode bits stay cleared.
  always_comb begin
    set_s = rise_s;
    clr_s = '0;
    if (wr_s && (i_addr == IRQ_SWSET)) begin
      set_s = rise_s | wdata_s;
    end else begin
      set_s = rise_s;
    end
    if (wr_s && (i_addr == IRQ_PENDING)) begin
      clr_s = wdata_s;
    end else begin
      clr_s = '0;
    end
    latch_nxt_s = mode_r & (set_s | (latch_r & ~clr_s));
  end

  // ACTIVE register image.
  always_comb begin
    active_s = 8'h00;
    if (act_valid_s) begin
      active_s[ACTIVE_VALID_BIT] = 1'b1;
      active_s[2:0]              = act_idx_s;
    end else begin
      active_s = 8'h00;
    end
  end

  // Read mux over pre-update register values.
  always_comb begin
    rdata_s = 8'h00;
    case (i_addr)
      IRQ_RAW:     rdata_s = 8'(i_src);
      IRQ_ENABLE:  rdata_s = 8'(enable_r);
      IRQ_MODE:    rdata_s = 8'(mode_r);
      IRQ_PENDING: rdata_s = 8'(pending_s);
      IRQ_ACTIVE:  rdata_s = active_s;
      default:     rdata_s = 8'h00;
    endcase
  end

  // State registers, bus writes, read-data capture and the CPU request flop.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      enable_r <= '0;
      mode_r   <= '0;
      latch_r  <= '0;
      src_q_r  <= '0;
      o_data   <= 8'h00;
      o_irq    <= 1'b0;
    end else begin
      src_q_r <= i_src;
      latch_r <= latch_nxt_s;
      o_irq   <= act_valid_s;
      if (wr_s && (i_addr == IRQ_ENABLE)) begin
        enable_r <= wdata_s;
      end else begin
        enable_r <= enable_r;
      end
      if (wr_s && (i_addr == IRQ_MODE)) begin
        mode_r <= wdata_s;
      end else begin
        mode_r <= mode_r;
      end
      if (rd_s) begin
        o_data <= rdata_s;
      end else begin
        o_data <= o_data;
      end
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized traffic against a behavioural model.
module tb_irq_controller;
  localparam int N = 6;
  localparam logic [7:0] MASK = 8'h3F;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] src;
  logic [2:0]   addr;
  logic [7:0]   wdata;
  logic         rw;
  logic         en;
  logic [7:0]   rdata;
  logic         irq;

  int n_vec;
  int n_err;

  // Behavioural model state
  logic [7:0] m_enable, m_mode, m_latch, m_prev, m_data;
  logic       m_irq;

  irq_controller #(.NUM_SRC(N)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_src     (src),
    .i_addr    (addr),
    .i_data    (wdata),
    .i_rw      (rw),
    .i_en      (en),
    .o_data    (rdata),
    .o_irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs that were held at that edge.
  task automatic model_tick();
    logic [7:0] s, pend, act, rv, nl;
    bit found;
    s = 8'(src);
    if (!rst_n) begin
      m_enable = 8'h00; m_mode = 8'h00; m_latch = 8'h00;
      m_prev = 8'h00; m_data = 8'h00; m_irq = 1'b0;
    end else begin
      pend = 8'h00;
      for (int i = 0; i < N; i++) pend[i] = m_mode[i] ? m_latch[i] : s[i];
      act = 8'h00;
      found = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && pend[i] && m_enable[i]) begin
          act = 8'h80 + 8'(i);
          found = 1;
        end
      end
      case (addr)
        3'd0: rv = s;
        3'd1: rv = m_enable;
        3'd2: rv = m_mode;
        3'd3: rv = pend;
        3'd4: rv = act;
        default: rv = 8'h00;
      endcase
      if (en && rw) m_data = rv;
      m_irq = found;
      nl = 8'h00;
      for (int i = 0; i < N; i++) begin
        if (!m_mode[i]) nl[i] = 1'b0;
        else if ((s[i] && !m_prev[i]) || (en && !rw && addr == 3'd5 && wdata[i])) nl[i] = 1'b1;
        else if (en && !rw && addr == 3'd3 && wdata[i]) nl[i] = 1'b0;
        else nl[i] = m_latch[i];
      end
      m_latch = nl;
      if (en && !rw && addr == 3'd1) m_enable = wdata & MASK;
      if (en && !rw && addr == 3'd2) m_mode = wdata & MASK;
      m_prev = s;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_tick();
    check_val("irq", {7'd0, irq}, {7'd0, m_irq});
    check_val("rdata", rdata, m_data);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    addr = a; wdata = d; rw = 1'b0; en = 1'b1;
    cycle();
    en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v);
    addr = a; rw = 1'b1; en = 1'b1;
    cycle();
    en = 1'b0;
    v = rdata;
  endtask

  initial begin
    logic [7:0] v;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; src = '0; addr = 3'd0; wdata = 8'h00; rw = 1'b1; en = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    check_val("reset_irq", {7'd0, irq}, 8'h00);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      check_val("reset_read", v, 8'h00);
    end
    wr(3'd6, 8'hFF);
    rd(3'd6, v);
    check_val("reserved_read", v, 8'h00);

    // Edge path
    wr(3'd2, 8'h01);
    wr(3'd1, 8'h01);
    src = 6'h01;
    cycle();
    check_val("edge_k_irq", {7'd0, irq}, 8'h00);
    src = 6'h00;
    cycle();
    check_val("edge_k1_irq", {7'd0, irq}, 8'h01);
    rd(3'd3, v);
    check_val("edge_pending", v, 8'h01);
    rd(3'd4, v);
    check_val("edge_active", v, 8'h80);
    src = 6'h01;
    cycle();
    cycle();
    wr(3'd3, 8'h01);
    cycle();
    check_val("w1c_irq", {7'd0, irq}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("held_irq", {7'd0, irq}, 8'h00);
    end
    src = 6'h00;

    // Level path
    wr(3'd2, 8'h00);
    wr(3'd1, 8'h04);
    src = 6'h04;
    cycle();
    cycle();
    check_val("level_irq", {7'd0, irq}, 8'h01);
    rd(3'd4, v);
    check_val("level_active", v, 8'h82);
    wr(3'd3, 8'h04);
    rd(3'd3, v);
    check_val("level_w1c_pending", v, 8'h04);
    src = 6'h00;
    cycle();
    check_val("level_drop_irq", {7'd0, irq}, 8'h00);

    // Priority and mask
    src = 6'h28;
    wr(3'd1, 8'h28);
    rd(3'd4, v);
    check_val("prio_active", v, 8'h83);
    wr(3'd1, 8'h20);
    rd(3'd4, v);
    check_val("mask_active", v, 8'h85);
    wr(3'd1, 8'h00);
    rd(3'd4, v);
    check_val("masked_active", v, 8'h00);
    check_val("masked_irq", {7'd0, irq}, 8'h00);
    rd(3'd3, v);
    check_val("masked_pending", v, 8'h28);
    src = 6'h00;

    // Collision, SWSET, reset while active
    wr(3'd2, 8'h02);
    wr(3'd1, 8'h02);
    src = 6'h02;
    wr(3'd3, 8'h02);
    rd(3'd3, v);
    check_val("collision_pending", v, 8'h02);
    src = 6'h00;
    wr(3'd2, 8'h00);
    wr(3'd5, 8'h02);
    wr(3'd2, 8'h02);
    rd(3'd3, v);
    check_val("swset_level_pending", v, 8'h00);
    wr(3'd5, 8'h02);
    rd(3'd3, v);
    check_val("swset_edge_pending", v, 8'h02);
    cycle();
    check_val("swset_irq", {7'd0, irq}, 8'h01);
    rst_n = 1'b0;
    cycle();
    check_val("reset_active_irq", {7'd0, irq}, 8'h00);
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) src = N'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      en    = ($urandom_range(0, 1) == 1);
      rw    = ($urandom_range(0, 1) == 1);
      addr  = 3'($urandom_range(0, 7));
      wdata = 8'($urandom);
      cycle();
    end
    en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
